// File: rtl/mem_loader.sv
// Boot-time image loader: streams bytes over valid/ready into consecutive data-memory addresses.
// Optional trailing checksum byte verification is enabled by defining MEM_LOADER_CHECKSUM_EN.
module mem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [7:0]        loader_out,
  output logic [ADDR_W-1:0] loader_addr,
  output logic              loader_we,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned DATA_W = 8;

`ifdef MEM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    remain_q, remain_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic [ADDR_W-1:0]   laddr_q, laddr_d;
  logic                accept;

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                error_q, error_d;
`endif

  // Handshake uses the registered ready so acceptance is a pure function of flop state and in_valid.
  assign accept = in_valid && in_ready_q;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      out_q      <= '0;
      laddr_q    <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      we_q       <= we_d;
      out_q      <= out_d;
      laddr_q    <= laddr_d;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      error_q    <= error_d;
`endif
    end
  end

  // Next state; output registers are loaded from the next-state decode so they align with the state.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    we_d     = 1'b0;
    out_d    = out_q;
    laddr_d  = laddr_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
    error_d  = error_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
          error_d = 1'b0;
`endif
          if (length != '0) begin
            addr_d   = base_addr;
            remain_d = length;
            state_d  = LOAD;
          end else begin
`ifdef MEM_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
`endif
          end
        end
      end

      LOAD: begin
        // Abort also cancels the write that an acceptance in this same cycle would schedule.
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          we_d     = 1'b1;
          out_d    = in_data;
          laddr_d  = addr_q;
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - LEN_W'(1);
`ifdef MEM_LOADER_CHECKSUM_EN
          sum_d    = sum_q + in_data;
`endif
          if (remain_q == LEN_W'(1)) begin
`ifdef MEM_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
`endif
          end
        end
      end

`ifdef MEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          if (in_data != sum_q) begin
            error_d = 1'b1;
          end
          state_d = DONE;
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ready/busy cover every state that is consuming the stream.
  always_comb begin
    in_ready_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    if (state_d == LOAD) begin
      in_ready_d = 1'b1;
      busy_d     = 1'b1;
    end
`ifdef MEM_LOADER_CHECKSUM_EN
    if (state_d == CHECK) begin
      in_ready_d = 1'b1;
      busy_d     = 1'b1;
    end
`endif
    if (state_d == DONE) begin
      done_d = 1'b1;
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign loader_we   = we_q;
  assign loader_out  = out_q;
  assign loader_addr = laddr_q;
`ifdef MEM_LOADER_CHECKSUM_EN
  assign error       = error_q;
`else
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_mem_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] loader_out;
  logic [7:0] loader_addr;
  logic       loader_we;
  logic       busy;
  logic       done;
  logic       error;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  n_wr = 0;
  int  n_done = 0;
  int  cyc = 0;
  int  last_wr_cyc = 0;
  int  done_cyc = 0;

  mem_loader #(.ADDR_W(8), .LEN_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .loader_out(loader_out), .loader_addr(loader_addr), .loader_we(loader_we),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: every write must match the head of the expected queue, including its cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (loader_we) begin
        n_wr++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          check("wr_addr", loader_addr, w.a);
          check("wr_data", loader_out, w.d);
          check("wr_cycle", cyc, w.c);
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        check("busy_at_done", busy, 0);
      end
    end
  end

  task automatic do_start(input logic [7:0] base, input int len);
    repeat (2) begin @(posedge clk); #1; end
    base_addr = base;
    length    = 9'(len);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit push, input logic [7:0] a);
    bit acc;
    int t;
    in_valid = 1'b1;
    in_data  = d;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = in_ready;
      if (acc && push) begin
        wr_t w;
        w.a = a; w.d = d; w.c = cyc + 1;
        exp_q.push_back(w);
      end
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (n_done == d0 && t < 40) begin
      @(negedge clk); #1;
      t++;
    end
  endtask

  // Full load: data byte i = first + step*i, optional gap cycles, optional start poke mid-load.
  task automatic run_load(input string nm, input logic [7:0] base, input int len, input int gap,
                          input logic [7:0] first, input logic [7:0] step, input int bad,
                          input bit poke);
    int w0, d0;
    logic [7:0] sum, d;
    w0 = n_wr; d0 = n_done; sum = 8'h00;
    do_start(base, len);
    for (int i = 0; i < len; i++) begin
      d = 8'(first + 8'(step * i));
      if (poke && i == 1) begin start = 1'b1; base_addr = 8'h00; length = 9'd1; end
      send_byte(d, 1'b1, 8'(base + 8'(i)));
      start = 1'b0;
      sum = 8'(sum + d);
      if (i < len - 1) repeat (gap) begin @(posedge clk); #1; end
    end
`ifdef MEM_LOADER_CHECKSUM_EN
    send_byte(8'(sum + 8'(bad)), 1'b0, 8'h00);
`endif
    wait_done(d0);
    @(negedge clk); #1;
    check({nm, "_done_count"}, n_done - d0, 1);
    check({nm, "_write_count"}, n_wr - w0, len);
    check({nm, "_queue_empty"}, exp_q.size(), 0);
    check({nm, "_busy_after"}, busy, 0);
    check({nm, "_ready_after"}, in_ready, 0);
`ifdef MEM_LOADER_CHECKSUM_EN
    check({nm, "_error"}, error, (bad != 0) ? 1 : 0);
`else
    check({nm, "_error"}, error, 0);
    if (len > 0) check({nm, "_done_with_last_write"}, done_cyc, last_wr_cyc);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = 8'h00; length = 9'd0;
    in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", loader_we, 0);
    check("rst_out", loader_out, 0);
    check("rst_addr", loader_addr, 0);
    check("rst_error", error, 0);
    rst_n = 1'b1;

    run_load("basic", 8'h10, 4, 0, 8'hA1, 8'h11, 0, 1'b0);
    run_load("wrap", 8'hFE, 4, 0, 8'h01, 8'h01, 0, 1'b1);
    run_load("stall", 8'h20, 3, 2, 8'h55, 8'h10, 0, 1'b0);
    run_load("len0", 8'h33, 0, 0, 8'h00, 8'h00, 0, 1'b0);
    run_load("full256", 8'h80, 256, 0, 8'h00, 8'h01, 0, 1'b0);

    // Abort in the same cycle the third byte is accepted.
    w0 = n_wr; d0 = n_done;
    do_start(8'h40, 8);
    send_byte(8'h11, 1'b1, 8'h40);
    send_byte(8'h22, 1'b1, 8'h41);
    abort = 1'b1;
    send_byte(8'h33, 1'b0, 8'h00);
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_ready", in_ready, 0);
    check("abort_we", loader_we, 0);
    repeat (5) @(negedge clk);
    #1;
    check("abort_writes", n_wr - w0, 2);
    check("abort_no_done", n_done - d0, 0);
    check("abort_queue", exp_q.size(), 0);
    run_load("after_abort", 8'h50, 2, 0, 8'h77, 8'h01, 0, 1'b0);

    // Reset while byte 2 of 5 is on the stream.
    w0 = n_wr;
    do_start(8'h60, 5);
    send_byte(8'h5A, 1'b1, 8'h60);
    @(negedge clk); #1;
    in_valid = 1'b1; in_data = 8'h6B;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_we", loader_we, 0);
    check("mid_rst_out", loader_out, 0);
    check("mid_rst_addr", loader_addr, 0);
    check("mid_rst_error", error, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    check("mid_rst_writes", n_wr - w0, 1);
    check("mid_rst_queue", exp_q.size(), 0);
    check("mid_rst_busy_after", busy, 0);

`ifdef MEM_LOADER_CHECKSUM_EN
    run_load("csum_good", 8'h70, 3, 0, 8'h01, 8'h01, 0, 1'b0);
    run_load("csum_bad", 8'h70, 3, 0, 8'h01, 8'h01, 1, 1'b0);
    run_load("csum_clear", 8'h90, 2, 1, 8'h10, 8'h20, 0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
